// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU controller / datapath pair: control-word bit
// positions (y_k lives at ctrl[k-1]) and condition-word bit positions (x_k at cond[k-1]).
package cpu_ctrl_pkg;

  localparam int CTRL_W = 29;
  localparam int COND_W = 14;

  localparam int Y_CLR     = 0;
  localparam int Y_SET     = 1;
  localparam int Y_FETCH_A = 2;
  localparam int Y_FETCH_B = 3;
  localparam int Y_ADD     = 8;
  localparam int Y_SUB     = 9;
  localparam int Y_TOGGLE  = 10;
  localparam int Y_ALU_A   = 11;
  localparam int Y_ALU_B   = 13;
  localparam int Y_END     = 18;
  localparam int Y_ST_A    = 26;
  localparam int Y_ST_B    = 27;

  localparam int C_MODE   = 0;
  localparam int C_IRV    = 1;
  localparam int C_IR_LSB = 2;
  localparam int C_Z      = 10;
  localparam int C_C      = 11;
  localparam int C_N      = 12;
  localparam int C_V      = 13;

endpackage

// File: rtl/cpu_instr_fifo.sv
// Byte-wide synchronous instruction FIFO. rdata always shows the head entry,
// so a pop takes it in the same cycle. A push is taken when not full, or when full with a pop in the same cycle.
module cpu_instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en, pop_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_en && !pop_en) count_d = count_q + (AW+1)'(1);
    else if (pop_en && !push_en) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_status_responder.sv
// Datapath side of the CPU control loop: decodes the controller's y-word and
// returns the x-word from registered IR, accumulator flags and mode state.
module cpu_status_responder
  import cpu_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [COND_W-1:0] cond,
  output logic [7:0]        acc_out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  retired,
  output logic [CNT_W-1:0]  stalls
);

  logic fetch, end_op, alu_en, store;
  logic fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic unused_ctrl;

  logic [7:0]       ir_q, ir_d, acc_q, acc_d, acc_out_q, acc_out_d;
  logic             ir_valid_q, ir_valid_d, mode_q, mode_d, out_valid_q, out_valid_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic [CNT_W-1:0] retired_q, retired_d, stalls_q, stalls_d;
  logic [8:0]       sum, diff;

  assign fetch  = ctrl[Y_FETCH_A] && ctrl[Y_FETCH_B];
  assign end_op = ctrl[Y_END];
  assign alu_en = ctrl[Y_ALU_A] && ctrl[Y_ALU_B];
  assign store  = ctrl[Y_ST_A] && ctrl[Y_ST_B];
  assign unused_ctrl = ^ctrl;

  // Handshake: a byte is transferred on a posedge where in_valid && in_ready;
  // in_ready is registered (!full) and never depends on in_valid or ctrl.
  assign in_ready = !fifo_full;

  cpu_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .wdata (in_data),
    .pop   (fetch),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sum  = {1'b0, acc_q} + {1'b0, ir_q};
  assign diff = {1'b0, acc_q} - {1'b0, ir_q};

  always_comb begin
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    acc_d       = acc_q;
    z_d         = z_q;
    c_d         = c_q;
    n_d         = n_q;
    v_d         = v_q;
    mode_d      = mode_q;
    retired_d   = retired_q;
    stalls_d    = stalls_q;
    acc_out_d   = acc_out_q;
    out_valid_d = store;

    if (store) acc_out_d = acc_q;

    if (alu_en && ctrl[Y_ADD]) begin
      acc_d = sum[7:0];
      c_d   = sum[8];
      v_d   = (acc_q[7] == ir_q[7]) && (sum[7] != acc_q[7]);
      z_d   = (sum[7:0] == 8'h00);
      n_d   = sum[7];
    end else if (alu_en && ctrl[Y_SUB]) begin
      acc_d = diff[7:0];
      c_d   = diff[8];
      v_d   = (acc_q[7] != ir_q[7]) && (diff[7] != acc_q[7]);
      z_d   = (diff[7:0] == 8'h00);
      n_d   = diff[7];
    end

    if (ctrl[Y_CLR])         mode_d = 1'b0;
    else if (ctrl[Y_SET])    mode_d = 1'b1;
    else if (ctrl[Y_TOGGLE]) mode_d = !mode_q;

    // A fetch decides ir_valid even when the instruction also ends this cycle.
    if (fetch) begin
      if (fifo_empty) begin
        ir_valid_d = 1'b0;
        stalls_d   = stalls_q + CNT_W'(1);
      end else begin
        ir_d       = fifo_rdata;
        ir_valid_d = 1'b1;
      end
    end else if (end_op) begin
      ir_valid_d = 1'b0;
    end
    if (end_op) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      acc_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      mode_q      <= 1'b0;
      retired_q   <= '0;
      stalls_q    <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      c_q         <= c_d;
      n_q         <= n_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      retired_q   <= retired_d;
      stalls_q    <= stalls_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    cond                       = '0;
    cond[C_MODE]               = mode_q;
    cond[C_IRV]                = ir_valid_q;
    cond[C_IR_LSB +: 8]        = ir_q;
    cond[C_Z]                  = z_q;
    cond[C_C]                  = c_q;
    cond[C_N]                  = n_q;
    cond[C_V]                  = v_q;
  end

  assign acc_out   = acc_out_q;
  assign out_valid = out_valid_q;
  assign retired   = retired_q;
  assign stalls    = stalls_q;

endmodule

// File: tb/tb_cpu_status_responder.sv
// Bench for cpu_status_responder: ctrl driven on negedge like the controller,
// outputs checked 1 ns after posedge against a spec-level model and byte queue.
module tb_cpu_status_responder;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [28:0]   ctrl;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [13:0]   cond;
  logic [7:0]    acc_out;
  logic          out_valid;
  logic [CW-1:0] retired;
  logic [CW-1:0] stalls;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]    exp_q[$];
  logic [7:0]    m_ir, m_acc, m_accout;
  logic          m_irv, m_mode, m_ov, m_z, m_c, m_n, m_v;
  logic [CW-1:0] m_ret, m_stl;

  cpu_status_responder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl      (ctrl),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cond      (cond),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .retired   (retired),
    .stalls    (stalls)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] m_cond();
    return {m_v, m_n, m_c, m_z, m_ir, m_irv, m_mode};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ir = 8'h00; m_acc = 8'h00; m_accout = 8'h00;
    m_irv = 1'b0; m_mode = 1'b0; m_ov = 1'b0;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
    m_ret = '0; m_stl = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    ctrl = '0; in_valid = 1'b0; in_data = 8'h00;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one controller cycle and advances the model by the same posedge.
  task automatic step(input logic [28:0] c, input logic v, input logic [7:0] d);
    logic       push_ok;
    logic [7:0] op, r;
    logic [8:0] s;
    @(negedge clk);
    push_ok = v && (exp_q.size() < DEPTH);
    op = m_ir;
    m_ov = c[26] && c[27];
    if (m_ov) m_accout = m_acc;
    if (c[11] && c[13] && (c[8] || c[9])) begin
      if (c[8]) begin
        s = {1'b0, m_acc} + {1'b0, op};
        r = s[7:0];
        m_c = s[8];
        m_v = (m_acc[7] == op[7]) && (r[7] != m_acc[7]);
      end else begin
        r = m_acc - op;
        m_c = (m_acc < op);
        m_v = (m_acc[7] != op[7]) && (r[7] != m_acc[7]);
      end
      m_z = (r == 8'h00);
      m_n = r[7];
      m_acc = r;
    end
    if (c[0]) m_mode = 1'b0;
    else if (c[1]) m_mode = 1'b1;
    else if (c[10]) m_mode = !m_mode;
    if (c[2] && c[3]) begin
      if (exp_q.size() > 0) begin
        m_ir = exp_q.pop_front();
        m_irv = 1'b1;
      end else begin
        m_irv = 1'b0;
        m_stl = m_stl + 1'b1;
      end
    end else if (c[18]) begin
      m_irv = 1'b0;
    end
    if (c[18]) m_ret = m_ret + 1'b1;
    if (push_ok) exp_q.push_back(d);
    ctrl = c; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    ctrl = '0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (cond !== 14'h0000) begin n_fail++; $display("FAIL reset_cond: got %h expected 0000", cond); end
    n_tests++; if (acc_out !== 8'h00) begin n_fail++; $display("FAIL reset_acc_out: got %h expected 00", acc_out); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    // Build up nonzero state, then reset asynchronously between edges.
    step(29'h0000000, 1'b1, 8'h11);
    step(29'h000000C, 1'b1, 8'h22);
    step(29'h0042902, 1'b0, 8'h00);
    step(29'h000000C, 1'b0, 8'h00);
    step(29'h000000C, 1'b0, 8'h00);
    step(29'h0C000000, 1'b0, 8'h00);
    n_tests++; if (stalls !== 16'd1 || retired !== 16'd1) begin n_fail++; $display("FAIL pre_reset_counters: got %0d/%0d expected 1/1", stalls, retired); end
    in_valid = 1'b1; in_data = 8'h77;
    rst = 1'b1;
    #1;
    n_tests++; if (cond !== 14'h0000) begin n_fail++; $display("FAIL async_reset_cond: got %h expected 0000", cond); end
    n_tests++; if (acc_out !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_out: got %h/%b expected 00/0", acc_out, out_valid); end
    n_tests++; if (retired !== '0 || stalls !== '0) begin n_fail++; $display("FAIL async_reset_counters: got %0d/%0d expected 0/0", retired, stalls); end
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    // The discarded in-flight byte must not be fetchable.
    step(29'h000000C, 1'b0, 8'h00);
    n_tests++; if (cond[1] !== 1'b0 || stalls !== 16'd1) begin n_fail++; $display("FAIL post_reset_fifo_empty: got irv=%b stalls=%0d expected 0/1", cond[1], stalls); end
  endtask

  task automatic test_fetch();
    apply_reset();
    step(29'h0000000, 1'b1, 8'h5A);
    step(29'h000000C, 1'b0, 8'h00);
    n_tests++; if (cond[1] !== 1'b1 || cond[9:2] !== 8'h5A) begin n_fail++; $display("FAIL fetch: got irv=%b ir=%h expected 1/5a", cond[1], cond[9:2]); end
    step(29'h000000C, 1'b0, 8'h00);
    n_tests++; if (cond[1] !== 1'b0 || cond[9:2] !== 8'h5A || stalls !== 16'd1) begin n_fail++; $display("FAIL fetch_empty: got irv=%b ir=%h stalls=%0d expected 0/5a/1", cond[1], cond[9:2], stalls); end
    step(29'h000000C, 1'b1, 8'h33);
    n_tests++; if (cond[1] !== 1'b0 || stalls !== 16'd2) begin n_fail++; $display("FAIL no_bypass: got irv=%b stalls=%0d expected 0/2", cond[1], stalls); end
    step(29'h000000C, 1'b0, 8'h00);
    n_tests++; if (cond[1] !== 1'b1 || cond[9:2] !== 8'h33) begin n_fail++; $display("FAIL fetch_after_bypass: got irv=%b ir=%h expected 1/33", cond[1], cond[9:2]); end
  endtask

  task automatic test_add();
    apply_reset();
    step(29'h0000000, 1'b1, 8'h7F);
    step(29'h000000C, 1'b0, 8'h00);
    step(29'h0002900, 1'b0, 8'h00);
    n_tests++; if (cond[13:10] !== 4'b0000) begin n_fail++; $display("FAIL add_7f_flags: got %b expected 0000", cond[13:10]); end
    step(29'h0C000000, 1'b0, 8'h00);
    n_tests++; if (acc_out !== 8'h7F || out_valid !== 1'b1) begin n_fail++; $display("FAIL store_7f: got %h/%b expected 7f/1", acc_out, out_valid); end
    step(29'h0000000, 1'b1, 8'h01);
    step(29'h000000C, 1'b0, 8'h00);
    step(29'h0002900, 1'b0, 8'h00);
    n_tests++; if (cond[13:10] !== 4'b1100) begin n_fail++; $display("FAIL add_overflow_flags: got VNCZ=%b expected 1100", cond[13:10]); end
    step(29'h0C002900, 1'b0, 8'h00);
    n_tests++; if (acc_out !== 8'h80 || out_valid !== 1'b1) begin n_fail++; $display("FAIL store_pre_alu: got %h/%b expected 80/1", acc_out, out_valid); end
    step(29'h0000000, 1'b0, 8'h00);
    n_tests++; if (out_valid !== 1'b0 || acc_out !== 8'h80) begin n_fail++; $display("FAIL store_one_cycle: got %h/%b expected 80/0", acc_out, out_valid); end
    n_tests++; if (cond[13:10] !== 4'b0100) begin n_fail++; $display("FAIL add_81_flags: got VNCZ=%b expected 0100", cond[13:10]); end
    step(29'h0C000000, 1'b0, 8'h00);
    n_tests++; if (acc_out !== 8'h81) begin n_fail++; $display("FAIL store_81: got %h expected 81", acc_out); end
  endtask

  task automatic test_sub();
    apply_reset();
    step(29'h0000000, 1'b1, 8'h01);
    step(29'h000000C, 1'b0, 8'h00);
    step(29'h0002A00, 1'b0, 8'h00);
    n_tests++; if (cond[13:10] !== 4'b0110) begin n_fail++; $display("FAIL sub_borrow_flags: got VNCZ=%b expected 0110", cond[13:10]); end
    step(29'h0000900, 1'b0, 8'h00);
    n_tests++; if (cond[13:10] !== 4'b0110) begin n_fail++; $display("FAIL alu_half_select: got VNCZ=%b expected 0110", cond[13:10]); end
    step(29'h0C000000, 1'b0, 8'h00);
    n_tests++; if (acc_out !== 8'hFF) begin n_fail++; $display("FAIL sub_result: got %h expected ff", acc_out); end
    step(29'h0002B00, 1'b0, 8'h00);
    n_tests++; if (cond[13:10] !== 4'b0011) begin n_fail++; $display("FAIL add_priority_flags: got VNCZ=%b expected 0011", cond[13:10]); end
    step(29'h0C000000, 1'b0, 8'h00);
    n_tests++; if (acc_out !== 8'h00) begin n_fail++; $display("FAIL add_priority_result: got %h expected 00", acc_out); end
    apply_reset();
    step(29'h0000000, 1'b1, 8'h00);
    step(29'h000000C, 1'b0, 8'h00);
    step(29'h0002A00, 1'b0, 8'h00);
    n_tests++; if (cond[13:10] !== 4'b0001) begin n_fail++; $display("FAIL sub_zero_flags: got VNCZ=%b expected 0001", cond[13:10]); end
  endtask

  task automatic test_fifo_boundary();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(29'h0000000, 1'b1, 8'($urandom_range(0, 255)));
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_ready: got %b expected 0", in_ready); end
    step(29'h0000000, 1'b1, 8'hEE);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_overpush_ready: got %b expected 0", in_ready); end
    for (int i = 0; i <= DEPTH; i++) begin
      step(29'h000000C, 1'b0, 8'h00);
      if (i < DEPTH) begin
        n_tests++; if (cond[1] !== 1'b1 || cond[9:2] !== m_ir) begin n_fail++; $display("FAIL fifo_order_%0d: got irv=%b ir=%h expected 1/%h", i, cond[1], cond[9:2], m_ir); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_ready_%0d: got %b expected 1", i, in_ready); end
      end else begin
        n_tests++; if (cond[1] !== 1'b0 || stalls !== 16'd1) begin n_fail++; $display("FAIL fifo_underflow: got irv=%b stalls=%0d expected 0/1", cond[1], stalls); end
      end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    step(29'h0000002, 1'b0, 8'h00);
    n_tests++; if (cond[0] !== 1'b1) begin n_fail++; $display("FAIL mode_set: got %b expected 1", cond[0]); end
    step(29'h0000003, 1'b0, 8'h00);
    n_tests++; if (cond[0] !== 1'b0) begin n_fail++; $display("FAIL mode_clr_wins: got %b expected 0", cond[0]); end
    step(29'h0000400, 1'b0, 8'h00);
    n_tests++; if (cond[0] !== 1'b1) begin n_fail++; $display("FAIL mode_toggle1: got %b expected 1", cond[0]); end
    step(29'h0000400, 1'b0, 8'h00);
    n_tests++; if (cond[0] !== 1'b0) begin n_fail++; $display("FAIL mode_toggle2: got %b expected 0", cond[0]); end
    step(29'h0000402, 1'b0, 8'h00);
    n_tests++; if (cond[0] !== 1'b1) begin n_fail++; $display("FAIL mode_set_over_toggle: got %b expected 1", cond[0]); end
    step(29'h0000401, 1'b1, 8'hAB);
    n_tests++; if (cond[0] !== 1'b0) begin n_fail++; $display("FAIL mode_clr_over_toggle: got %b expected 0", cond[0]); end
    step(29'h004000C, 1'b0, 8'h00);
    n_tests++; if (retired !== 16'd1 || cond[1] !== 1'b1 || cond[9:2] !== 8'hAB) begin n_fail++; $display("FAIL end_with_fetch: got ret=%0d irv=%b ir=%h expected 1/1/ab", retired, cond[1], cond[9:2]); end
    step(29'h0040000, 1'b0, 8'h00);
    n_tests++; if (retired !== 16'd2 || cond[1] !== 1'b0) begin n_fail++; $display("FAIL end_alone: got ret=%0d irv=%b expected 2/0", retired, cond[1]); end
  endtask

  task automatic test_random();
    logic [28:0] c;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      c = 29'($urandom);
      step(c, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      n_tests++; if (cond !== m_cond()) begin n_fail++; $display("FAIL rand_cond_%0d: got %h expected %h", i, cond, m_cond()); end
      n_tests++; if (acc_out !== m_accout || out_valid !== m_ov) begin n_fail++; $display("FAIL rand_store_%0d: got %h/%b expected %h/%b", i, acc_out, out_valid, m_accout, m_ov); end
      n_tests++; if (retired !== m_ret || stalls !== m_stl) begin n_fail++; $display("FAIL rand_counters_%0d: got %0d/%0d expected %0d/%0d", i, retired, stalls, m_ret, m_stl); end
      n_tests++; if (in_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_in_ready_%0d: got %b expected %b", i, in_ready, exp_q.size() < DEPTH); end
    end
  endtask

  initial begin
    rst = 1'b1; ctrl = '0; in_valid = 1'b0; in_data = 8'h00;
    model_reset();
    #12;
    rst = 1'b0;
    #1;
    test_reset();
    test_fetch();
    test_add();
    test_sub();
    test_fifo_boundary();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
